// File: rtl/mod_dec_add_round_key_pkg.sv
// Shared types and constants for the decryption AddRoundKey block.
//   byte_t   : one 8-bit state byte
//   state_t  : 16-byte AES state, byte i = state[i]
//   state_e  : control FSM encoding (IDLE, XOR, DONE)
//   NB_BYTES : bytes per state, MAX_ROUND : highest legal round index
package mod_dec_add_round_key_pkg;

   localparam int NB_BYTES  = 16;
   localparam int MAX_ROUND = 14;

   typedef logic [7:0]                byte_t;
   typedef byte_t [NB_BYTES-1:0]      state_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XOR  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mod_dec_add_round_key_if.sv
// Handshake/data bundle for mod_dec_add_round_key.
//   startBit       : core enable, low = idle/abort
//   reg_in_status  : upstream register holds valid p/k/round
//   reg_out_status : downstream register busy / result consumed
//   p, k, round    : input state, round key, round index
//   o              : XOR result state
//   rd_comp        : one-cycle upstream read-complete pulse
//   ok, last       : result valid, result is final plaintext
//   err            : one-cycle illegal-round pulse
// Modports: master drives inputs of the block, slave is the block itself.
interface mod_dec_add_round_key_if;
   import mod_dec_add_round_key_pkg::*;

   logic         startBit;
   logic         reg_in_status;
   logic         reg_out_status;
   state_t       p;
   logic [127:0] k;
   logic [3:0]   round;
   state_t       o;
   logic         rd_comp;
   logic         ok;
   logic         last;
   logic         err;

   modport master (
      output startBit, reg_in_status, reg_out_status, p, k, round,
      input  o, rd_comp, ok, last, err
   );

   modport slave (
      input  startBit, reg_in_status, reg_out_status, p, k, round,
      output o, rd_comp, ok, last, err
   );

endinterface

// File: rtl/mod_dec_ark_byte.sv
// Single-byte AddRoundKey: y = a ^ b.
//   a : state byte, b : key byte, y : result byte
module mod_dec_ark_byte (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] y
);

   assign y = a ^ b;

endmodule

// File: rtl/mod_dec_add_round_key.sv
// Decryption AddRoundKey stage: captures a state and round key from the
// upstream register, XORs them and offers the result downstream.
//   clk, resetn : clock, async active-low reset
//   bus (slave) : handshake, data in (p/k/round) and result (o/ok/last)
// Build option DEC_ARK_PARALLEL_EN: all 16 bytes in one XOR cycle instead
// of one byte per cycle; handshake, reset and error behaviour unchanged.
module mod_dec_add_round_key
   import mod_dec_add_round_key_pkg::*;
(
   input  logic                   clk,
   input  logic                   resetn,
   mod_dec_add_round_key_if.slave bus
);

   state_e       state, state_n;
   state_t       p_q, o_q;
   logic [127:0] k_q;
   logic [3:0]   round_q;
   logic         accept, reject, wr;
   logic         rd_comp_q, ok_q, last_q, err_q;

`ifdef DEC_ARK_PARALLEL_EN
   state_t x_all;

   for (genvar g = 0; g < NB_BYTES; g++) begin : g_byte
      mod_dec_ark_byte u_byte (
         .a (p_q[g]),
         .b (k_q[8*g +: 8]),
         .y (x_all[g])
      );
   end
`else
   logic [3:0] cnt;
   byte_t      x_one;

   // Key byte i sits at bit 8*i, so the key index is cnt scaled by 8.
   mod_dec_ark_byte u_byte (
      .a (p_q[cnt]),
      .b (k_q[{cnt, 3'b000} +: 8]),
      .y (x_one)
   );
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_n;
   end

   // ---------------- FSM: next state / control ----------------
   always_comb begin
      state_n = state;
      accept  = 1'b0;
      reject  = 1'b0;
      wr      = 1'b0;
      case (state)
         IDLE: begin
            // A busy downstream register blocks both acceptance and err.
            if (bus.startBit && bus.reg_in_status && !bus.reg_out_status) begin
               if (bus.round <= 4'(MAX_ROUND)) begin
                  accept  = 1'b1;
                  state_n = XOR;
               end else begin
                  reject  = 1'b1;
               end
            end
         end
         XOR: begin
            // Abort takes priority: no byte is written on the abort edge.
            if (!bus.startBit) begin
               state_n = IDLE;
            end else begin
               wr = 1'b1;
`ifdef DEC_ARK_PARALLEL_EN
               state_n = DONE;
`else
               if (cnt == 4'(NB_BYTES-1)) state_n = DONE;
`endif
            end
         end
         DONE: begin
            if (!bus.startBit || bus.reg_out_status) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // ---------------- datapath and registered outputs ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         p_q       <= '0;
         k_q       <= '0;
         round_q   <= '0;
         o_q       <= '0;
         rd_comp_q <= 1'b0;
         ok_q      <= 1'b0;
         last_q    <= 1'b0;
         err_q     <= 1'b0;
`ifndef DEC_ARK_PARALLEL_EN
         cnt       <= '0;
`endif
      end else begin
         rd_comp_q <= accept;
         err_q     <= reject;
         ok_q      <= (state_n == DONE);
         last_q    <= (state_n == DONE) && (round_q == 4'd0);
         if (accept) begin
            p_q     <= bus.p;
            k_q     <= bus.k;
            round_q <= bus.round;
`ifndef DEC_ARK_PARALLEL_EN
            cnt     <= '0;
`endif
         end
         if (wr) begin
`ifdef DEC_ARK_PARALLEL_EN
            o_q      <= x_all;
`else
            o_q[cnt] <= x_one;
            cnt      <= cnt + 4'd1;
`endif
         end
      end
   end

   assign bus.o       = o_q;
   assign bus.rd_comp = rd_comp_q;
   assign bus.ok      = ok_q;
   assign bus.last    = last_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_mod_dec_add_round_key.sv
// Directed bench for mod_dec_add_round_key; expected states are
// hand-computed constants. Inputs change and outputs are sampled 1ns
// after the rising edge.
module tb_mod_dec_add_round_key;
   import mod_dec_add_round_key_pkg::*;

`ifdef DEC_ARK_PARALLEL_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 17;
`endif

   localparam logic [127:0] K_A   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K_B   = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] EXP_2 = 128'h010003020504070609080b0a0d0c0f0e; // 01 ^ K_A
   localparam logic [127:0] EXP_3 = 128'h0d0c0f0e09080b0a0504070601000302; // 02 ^ K_B
   localparam logic [127:0] EXP_6 = 128'h55545756515053525d5c5f5e59585b5a; // 55 ^ K_A

   logic clk = 1'b0;
   logic resetn;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mod_dec_add_round_key_if bus ();

   mod_dec_add_round_key dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents a legal request, checks rd_comp, busy ok, result latency,
   // o and last, with p/k/round scrambled right after acceptance.
   task automatic do_op(input logic [127:0] pv, input logic [127:0] kv,
                        input logic [3:0] rv, input logic [127:0] exp_o,
                        input logic exp_last);
      bus.startBit      = 1'b1;
      bus.reg_in_status = 1'b1;
      bus.p             = pv;
      bus.k             = kv;
      bus.round         = rv;
      step();
      chk("rd_comp after accept", 128'(bus.rd_comp), 128'd1);
      chk("ok at accept", 128'(bus.ok), 128'd0);
      bus.reg_in_status = 1'b0;
      bus.p             = '1;
      bus.k             = '1;
      bus.round         = 4'd3;
      for (int e = 2; e < LAT; e++) begin
         step();
         if (e == 2) chk("rd_comp single pulse", 128'(bus.rd_comp), 128'd0);
         chk("ok while busy", 128'(bus.ok), 128'd0);
      end
      step();
      chk("ok at latency", 128'(bus.ok), 128'd1);
      chk("rd_comp at done", 128'(bus.rd_comp), 128'd0);
      chk("o result", bus.o, exp_o);
      chk("last result", 128'(bus.last), 128'(exp_last));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      resetn             = 1'b0;
      bus.startBit       = 1'b0;
      bus.reg_in_status  = 1'b0;
      bus.reg_out_status = 1'b0;
      bus.p              = '0;
      bus.k              = '0;
      bus.round          = '0;
      #1;
      chk("reset o", bus.o, 128'd0);
      chk("reset ok", 128'(bus.ok), 128'd0);
      chk("reset rd_comp", 128'(bus.rd_comp), 128'd0);
      chk("reset last", 128'(bus.last), 128'd0);
      chk("reset err", 128'(bus.err), 128'd0);
      step();
      step();
      resetn = 1'b1;

      // Scenario 1: core disabled, nothing happens
      bus.p             = {16{8'h00}};
      bus.k             = K_A;
      bus.round         = 4'd14;
      bus.reg_in_status = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("s1 rd_comp", 128'(bus.rd_comp), 128'd0);
         chk("s1 ok", 128'(bus.ok), 128'd0);
         chk("s1 o", bus.o, 128'd0);
      end

      // Scenario 2: round 14, last = 0, result held until consumed
      do_op({16{8'h01}}, K_A, 4'd14, EXP_2, 1'b0);
      step();
      chk("s2 ok holds", 128'(bus.ok), 128'd1);
      bus.reg_out_status = 1'b1;
      step();
      chk("s2 ok drop", 128'(bus.ok), 128'd0);
      chk("s2 o holds", bus.o, EXP_2);
      bus.reg_out_status = 1'b0;

      // Scenario 4: illegal round
      bus.reg_in_status = 1'b1;
      bus.round         = 4'd15;
      bus.p             = {16{8'hAA}};
      step();
      chk("s4 err pulse", 128'(bus.err), 128'd1);
      chk("s4 no rd_comp", 128'(bus.rd_comp), 128'd0);
      bus.reg_in_status = 1'b0;
      step();
      chk("s4 err clears", 128'(bus.err), 128'd0);
      chk("s4 ok", 128'(bus.ok), 128'd0);
      chk("s4 o untouched", bus.o, EXP_2);

      // Scenario 5: downstream busy blocks acceptance (then scenario 3 data)
      bus.reg_out_status = 1'b1;
      bus.reg_in_status  = 1'b1;
      bus.p              = {16{8'h02}};
      bus.k              = K_B;
      bus.round          = 4'd0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("s5 blocked rd_comp", 128'(bus.rd_comp), 128'd0);
         chk("s5 blocked err", 128'(bus.err), 128'd0);
      end
      bus.reg_out_status = 1'b0;

      // Scenario 3: round 0 -> last
      do_op({16{8'h02}}, K_B, 4'd0, EXP_3, 1'b1);
      step();
      chk("s3 last holds", 128'(bus.last), 128'd1);
      bus.reg_out_status = 1'b1;
      step();
      chk("s3 ok drop", 128'(bus.ok), 128'd0);
      chk("s3 last drop", 128'(bus.last), 128'd0);
      bus.reg_out_status = 1'b0;

      // Scenario 6: reset mid-operation
      bus.startBit      = 1'b1;
      bus.reg_in_status = 1'b1;
      bus.p             = {16{8'h33}};
      bus.k             = K_A;
      bus.round         = 4'd9;
      step();
      bus.reg_in_status = 1'b0;
      for (int i = 0; i < 7; i++) step();
      resetn = 1'b0;
      #1;
      chk("s6 async o", bus.o, 128'd0);
      chk("s6 async ok", 128'(bus.ok), 128'd0);
      chk("s6 async rd_comp", 128'(bus.rd_comp), 128'd0);
      chk("s6 async last", 128'(bus.last), 128'd0);
      chk("s6 async err", 128'(bus.err), 128'd0);
      step();
      resetn = 1'b1;
      for (int i = 0; i < LAT + 1; i++) begin
         step();
         chk("s6 no resume ok", 128'(bus.ok), 128'd0);
         chk("s6 no resume rd_comp", 128'(bus.rd_comp), 128'd0);
      end
      do_op({16{8'h55}}, K_A, 4'd5, EXP_6, 1'b0);

      // Abort in DONE: ok drops, o keeps the result
      bus.startBit = 1'b0;
      step();
      chk("abort ok drop", 128'(bus.ok), 128'd0);
      chk("abort o holds", bus.o, EXP_6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mod_dec_add_round_key.md
MOD_DEC_ADD_ROUND_KEY -- requirements
Module: mod_dec_add_round_key

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock
- resetn  in  1  async active-low reset
- startBit  in  1  core enable; low = idle and abort
- reg_in_status  in  1  upstream state register full (1 = data on p/k valid)
- reg_out_status  in  1  downstream state register full (1 = result consumed, register busy)
- p  in  [15:0][7:0]  ciphertext/intermediate state, byte i = p[i]
- k  in  128  round key, byte i = k[8*i +: 8]
- round  in  4  decryption round index, 14 down to 0
- o  out  [15:0][7:0]  XOR result state
- rd_comp  out  1  one-cycle pulse, upstream read complete
- ok  out  1  result valid, load request to downstream
- last  out  1  result belongs to round 0, i.e. final plaintext
- err  out  1  one-cycle pulse, illegal round rejected

Function
REQ-003 FSM states SHALL be IDLE, XOR and DONE.
REQ-004 In IDLE, acceptance SHALL occur on an edge where startBit=1, reg_in_status=1, reg_out_status=0 and round<=14.
- On acceptance: capture p, k and round; clear byte counter cnt (4 bit); go to XOR.
- rd_comp SHALL be 1 for exactly the cycle after acceptance.
REQ-005 If round>14 under otherwise-accepting conditions, the block SHALL stay in IDLE, capture nothing and pulse err for one cycle.
REQ-006 In XOR, each edge SHALL write o[cnt] = p_q[cnt] ^ k_q[8*cnt +: 8] and increment cnt. At cnt==15 it SHALL write the byte and go to DONE.
REQ-007 ok SHALL be a registered output equal to (state==DONE); the result is complete after 17 edges counted from and including the acceptance edge.
REQ-008 last SHALL equal (round_q==0) while ok=1, and 0 otherwise.
REQ-009 In DONE, an edge with reg_out_status=1 SHALL return the FSM to IDLE and drop ok. o SHALL hold its value until the next XOR writes.
REQ-010 If startBit is sampled 0 in XOR or DONE, the FSM SHALL return to IDLE.
- ok SHALL be 0 on the next cycle.
- Bytes already written SHALL remain in o; the rest are unchanged.
REQ-011 Changes on p, k or round after acceptance SHALL NOT affect the current result.
REQ-012 If reg_in_status and reg_out_status are both 1 in IDLE, no acceptance SHALL occur.
REQ-013 The block SHALL NOT accept a new state while in XOR or DONE.

Reset
REQ-014 While resetn=0, the following SHALL hold asynchronously:
- state=IDLE, cnt=0
- o=0, rd_comp=0, ok=0, last=0, err=0
- captured registers = 0
REQ-015 Reset asserted mid-XOR SHALL discard the operation; after release, a new acceptance SHALL be required.

Configuration
REQ-016 Macro DEC_ARK_PARALLEL_EN:
- Defined: XOR SHALL process all 16 bytes in one edge, so ok=1 after 2 edges counted from and including acceptance; cnt is removed.
- Undefined: byte-serial operation as in REQ-006.
- Handshake, reset and error behaviour SHALL be identical in both builds.

Structure
REQ-017 A shared package SHALL hold:
- the state-type typedef (byte/state arrays)
- the FSM state enum
- constants NB_BYTES=16 and MAX_ROUND=14
REQ-018 One sub-module, mod_dec_ark_byte (combinational 8-bit XOR of byte and key byte), SHALL be instantiated once in serial mode and 16 times in parallel mode.

Verification
REQ-019 The bench SHALL cover:
- Scenario 1: p all 8'h00, k=128'h000102030405060708090a0b0c0d0e0f, round=14, startBit=0 -> no rd_comp, ok stays 0, o stays 0.
- Scenario 2: p all 8'h01, same k, round=14, startBit=1 -> rd_comp one cycle after acceptance, ok at edge 17 (2 if parallel), o[i]=8'h01^k byte i, last=0.
- Scenario 3: p all 8'h02, k=128'h0f0e0d0c0b0a09080706050403020100, round=0 -> o[i]=8'h02^k byte i, last=1; ok drops one edge after reg_out_status=1.
- Scenario 4: round=15, reg_in_status=1 -> err pulse, no rd_comp, state IDLE.
- Scenario 5: reg_out_status=1 in IDLE with valid input -> no acceptance until it drops, then acceptance next edge.
- Scenario 6: resetn pulsed low at XOR cnt=7 -> all outputs 0 immediately; a fresh acceptance completes correctly.
